aes128_arbiter: RTL and testbench
=================================

# aes128_arbiter

Round-robin arbiter and sequencer that shares one `aes128_fsm` core between up to four requesters, such as the CPU register interface and a DMA/stream engine.
- Accepts a full job (op, key, block) from the winning requester over a valid/ready handshake and captures it locally.
- Pulses the core start, waits for completion, then returns the result to the owner over a second valid/ready handshake.
- A watchdog aborts jobs that never complete, so a hung core cannot lock out other requesters.

## Interface
- `NUM_REQ`, default 2: number of requesters, legal range 2..4.
- `TIMEOUT`, default 64: maximum cycles in RUN before abort, at least 4.
- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous reset, active-high.
- `req_valid_i` in NUM_REQ: requester i has a job.
- `req_ready_o` out NUM_REQ: one-hot or zero; job i accepted when `req_valid_i[i] & req_ready_o[i]`.
- `req_op_i` in 2*NUM_REQ: op of requester i at bits [2i+1:2i], passed through unchanged.
- `req_key_i` in 128*NUM_REQ: key of requester i at [128i+127:128i].
- `req_data_i` in 128*NUM_REQ: input block of requester i, same packing as the key.
- `rsp_valid_o` out NUM_REQ: one-hot or zero; result is for requester i.
- `rsp_ready_i` in NUM_REQ: requester i takes its result.
- `rsp_result_o` out 128: shared result bus, valid only while some `rsp_valid_o` bit is set.
- `rsp_err_o` out 1: qualifies `rsp_valid_o`; 1 means timeout abort and the result is zero.
- `busy_o` out 1: state is not IDLE.
- `owner_o` out 2: index of the current or last granted requester.
- `core_start_o` out 1: single-cycle start pulse to the core.
- `core_op_o` out 2: captured op.
- `core_key_o` out 128: captured key.
- `core_data_o` out 128: captured block.
- `core_result_i` in 128: core result.
- `core_valid_i` in 1: core result valid, a level.
- `core_ready_i` in 1: core idle.

## Operation
- States:
  - IDLE: arbitrate.
  - ISSUE: pulse start.
  - RUN: wait for completion.
  - RESP: present result.
- IDLE arbitration:
  - The winner is the first requester with `req_valid_i` set, searching circularly from `last+1`.
  - `req_ready_o` is asserted combinationally only for the winner, and only when `core_ready_i=1`.
  - If `core_ready_i=0`, all `req_ready_o` bits are 0.
- On accept:
  - Capture op, key and data into the core-side registers.
  - Set `owner_o` and `last` to the winner.
  - Go to ISSUE.
  - The requester may change its inputs in the next cycle.
- ISSUE: `core_start_o=1` for exactly one cycle; clear the watchdog counter; go to RUN.
- RUN, completion: `core_valid_i=1` with registered previous value 0 (rising edge).
  - Capture `core_result_i` into the result register, clear error, go to RESP.
- RUN, timeout: the counter reaches TIMEOUT-1 without an edge.
  - Result register = 0, `rsp_err_o=1`, go to RESP.
  - If the edge and timeout occur in the same cycle, the edge wins.
- The `core_valid_i` edge detector register updates every cycle in all states, so a stale high valid from an earlier job is never mistaken for a new edge.
- RESP:
  - Assert `rsp_valid_o[owner]`; result and error are held stable until `rsp_ready_i[owner]`.
  - On that handshake go to IDLE.
  - No new grant occurs while in RESP.
  - `rsp_ready_i` of non-owners is ignored.
- `core_op/key/data_o` are registers; they hold the last captured job until the next accept.
- Watchdog counter width: $clog2(TIMEOUT).
- Reset:
  - Applies asynchronously at any point, including mid-RUN.
  - State goes to IDLE; all outputs and registers go to 0.
  - `last` goes to NUM_REQ-1, so requester 0 has first priority after reset.
  - The core is not reset by this block; if the core is mid-job, the result is dropped.

## Timing
- Accept in cycle T.
- `core_start_o=1` in T+1 (ISSUE).
- RUN starts in T+2.
- Core valid edge in cycle V, V ≥ T+2, gives `rsp_valid_o` in V+1.
- Response handshake in cycle R puts the block in IDLE at R+1; the earliest next accept is R+1.
- Back-to-back minimum job overhead is 4 cycles on top of core latency.
- Timeout with no edge: `rsp_valid_o` with `rsp_err_o=1` in T+2+TIMEOUT.
- `busy_o` is 1 from T+1 through R inclusive.
- `req_ready_o` is combinational from `req_valid_i`, `core_ready_i` and state.
- All other outputs are registered.

## Test plan
- **Single job, requester 0:**
  - Stimulus: encrypt with key 000102…0f and block 00112233…eeff; model core returns after 10 cycles.
  - Required: `core_start_o` pulses at T+1; `rsp_valid_o=01` with result 69c4e0d86a7b0430d8cdb78070b4c55a; `rsp_err_o=0`.
- **Contention:**
  - Stimulus: both requesters hold `req_valid_i` high for 4 jobs.
  - Required: grants alternate 0,1,0,1; `owner_o` matches every `rsp_valid_o`.
- **Backpressure:**
  - Stimulus: `rsp_ready_i` held low for 20 cycles in RESP while the other requester is valid.
  - Required: `rsp_result_o` stable; no `req_ready_o` asserted; `busy_o=1`.
- **Timeout:**
  - Stimulus: core never raises valid, TIMEOUT=64.
  - Required: `rsp_valid_o` with `rsp_err_o=1` and result 0 at T+66; next job then proceeds normally.
- **Stale valid / core not ready:**
  - Stimulus: `core_valid_i` held high from the previous job across a new start; separately, `core_ready_i=0` in IDLE.
  - Required: the stale high does not complete the new job until valid falls and rises again; with core not ready, `req_ready_o=0`.
- **Reset mid-RUN:**
  - Stimulus: `rst_i` pulsed during RUN.
  - Required: all outputs 0 immediately; after release, requester 0 wins when both requesters are valid.

Source files
------------

// File: rtl/aes128_arbiter.sv
// Round-robin arbiter and job sequencer sharing one aes128_fsm core between
// up to four requesters, with a watchdog that aborts jobs the core never finishes.
module aes128_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NUM_REQ-1:0]       req_valid_i,
   output logic [NUM_REQ-1:0]       req_ready_o,
   input  logic [2*NUM_REQ-1:0]     req_op_i,
   input  logic [128*NUM_REQ-1:0]   req_key_i,
   input  logic [128*NUM_REQ-1:0]   req_data_i,
   output logic [NUM_REQ-1:0]       rsp_valid_o,
   input  logic [NUM_REQ-1:0]       rsp_ready_i,
   output logic [127:0]             rsp_result_o,
   output logic                     rsp_err_o,
   output logic                     busy_o,
   output logic [1:0]               owner_o,
   output logic                     core_start_o,
   output logic [1:0]               core_op_o,
   output logic [127:0]             core_key_o,
   output logic [127:0]             core_data_o,
   input  logic [127:0]             core_result_i,
   input  logic                     core_valid_i,
   input  logic                     core_ready_i
);

   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, ISSUE, RUN, RESP} state_e;

   state_e          state_q, state_d;
   logic [1:0]      last_q, last_d;
   logic [1:0]      owner_q, owner_d;
   logic [1:0]      op_q, op_d;
   logic [127:0]    key_q, key_d;
   logic [127:0]    data_q, data_d;
   logic [127:0]    result_q, result_d;
   logic            err_q, err_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            vld_prev_q;

   // Requester buses padded to four slots so a 2-bit index never runs off the end.
   logic [3:0]             vld4, rdy4;
   logic [3:0][1:0]        op4;
   logic [3:0][127:0]      key4, data4;

   for (genvar g = 0; g < 4; g++) begin : g_pad
      if (g < NUM_REQ) begin : g_used
         assign vld4[g]  = req_valid_i[g];
         assign rdy4[g]  = rsp_ready_i[g];
         assign op4[g]   = req_op_i[2*g +: 2];
         assign key4[g]  = req_key_i[128*g +: 128];
         assign data4[g] = req_data_i[128*g +: 128];
      end else begin : g_unused
         assign vld4[g]  = 1'b0;
         assign rdy4[g]  = 1'b0;
         assign op4[g]   = '0;
         assign key4[g]  = '0;
         assign data4[g] = '0;
      end
   end

   logic       found;
   logic [1:0] win;
   logic [2:0] sum;

   // Circular search starting one past the last grant.
   always_comb begin
      found = 1'b0;
      win   = '0;
      sum   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         sum = 3'({1'b0, last_q}) + 3'(k);
         if (sum >= 3'(NUM_REQ)) sum = sum - 3'(NUM_REQ);
         if (!found && vld4[sum[1:0]]) begin
            found = 1'b1;
            win   = sum[1:0];
         end
      end
   end

   always_comb begin
      req_ready_o = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready_o[i] = !rst_i && (state_q == IDLE) && core_ready_i && found && (win == 2'(i));
      end
   end

   logic accept;
   logic core_edge;
   assign accept    = |(req_valid_i & req_ready_o);
   assign core_edge = core_valid_i & ~vld_prev_q;

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      owner_d  = owner_q;
      op_d     = op_q;
      key_d    = key_q;
      data_d   = data_q;
      result_d = result_q;
      err_d    = err_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               op_d    = op4[win];
               key_d   = key4[win];
               data_d  = data4[win];
               owner_d = win;
               last_d  = win;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = RUN;
         end
         RUN: begin
            // A real completion edge beats a simultaneous timeout.
            if (core_edge) begin
               result_d = core_result_i;
               err_d    = 1'b0;
               state_d  = RESP;
            end else if (cnt_q == CW'(TIMEOUT-1)) begin
               result_d = '0;
               err_d    = 1'b1;
               state_d  = RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            if (rdy4[owner_q]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         last_q     <= 2'(NUM_REQ-1);
         owner_q    <= '0;
         op_q       <= '0;
         key_q      <= '0;
         data_q     <= '0;
         result_q   <= '0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
         vld_prev_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         owner_q    <= owner_d;
         op_q       <= op_d;
         key_q      <= key_d;
         data_q     <= data_d;
         result_q   <= result_d;
         err_q      <= err_d;
         cnt_q      <= cnt_d;
         vld_prev_q <= core_valid_i;
      end
   end

   always_comb begin
      rsp_valid_o = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rsp_valid_o[i] = (state_q == RESP) && (owner_q == 2'(i));
      end
   end

   assign rsp_result_o = result_q;
   assign rsp_err_o    = err_q;
   assign busy_o       = (state_q != IDLE);
   assign owner_o      = owner_q;
   assign core_start_o = (state_q == ISSUE);
   assign core_op_o    = op_q;
   assign core_key_o   = key_q;
   assign core_data_o  = data_q;

endmodule

// File: tb/tb_aes128_arbiter.sv
// Directed bench for aes128_arbiter: core behaviour is scripted cycle by cycle
// so every latency and handshake point is known in advance.
module tb_aes128_arbiter;

   localparam int NR = 2;
   localparam int TO = 64;

   localparam logic [127:0] K0  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] D0  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K1  = 128'hfedcba9876543210fedcba9876543210;
   localparam logic [127:0] D1  = 128'h0f0e0d0c0b0a09080706050403020100;

   logic                clk_i = 1'b0;
   logic                rst_i = 1'b1;
   logic [NR-1:0]       req_valid_i = '0;
   logic [NR-1:0]       req_ready_o;
   logic [2*NR-1:0]     req_op_i = '0;
   logic [128*NR-1:0]   req_key_i = '0;
   logic [128*NR-1:0]   req_data_i = '0;
   logic [NR-1:0]       rsp_valid_o;
   logic [NR-1:0]       rsp_ready_i = '0;
   logic [127:0]        rsp_result_o;
   logic                rsp_err_o;
   logic                busy_o;
   logic [1:0]          owner_o;
   logic                core_start_o;
   logic [1:0]          core_op_o;
   logic [127:0]        core_key_o;
   logic [127:0]        core_data_o;
   logic [127:0]        core_result_i = '0;
   logic                core_valid_i = 1'b0;
   logic                core_ready_i = 1'b1;

   aes128_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_op_i(req_op_i), .req_key_i(req_key_i), .req_data_i(req_data_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_result_o(rsp_result_o), .rsp_err_o(rsp_err_o),
      .busy_o(busy_o), .owner_o(owner_o),
      .core_start_o(core_start_o), .core_op_o(core_op_o),
      .core_key_o(core_key_o), .core_data_o(core_data_o),
      .core_result_i(core_result_i), .core_valid_i(core_valid_i),
      .core_ready_i(core_ready_i)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_jobs;
      req_key_i  = {K1, K0};
      req_data_i = {D1, D0};
      req_op_i   = {2'b10, 2'b01};
   endtask

   // Starts in an IDLE cycle where requester `who` must win; ends in the next IDLE cycle.
   task automatic job(input int who, input int lat, input logic [127:0] res,
                      input bit drop, input string tag);
      logic [127:0] ek, ed;
      logic [1:0]   eo;
      logic [NR-1:0] oh;
      ek = req_key_i[128*who +: 128];
      ed = req_data_i[128*who +: 128];
      eo = req_op_i[2*who +: 2];
      oh = '0;
      oh[who] = 1'b1;
      #1;
      chk({tag, " ready"}, 128'(req_ready_o), 128'(oh));
      tick;
      if (drop) begin
         req_valid_i = '0;
         req_key_i   = '1;
         req_data_i  = '1;
         req_op_i    = '1;
      end
      #1;
      chk({tag, " start"}, 128'(core_start_o), 128'(1));
      chk({tag, " owner"}, 128'(owner_o), 128'(who));
      chk({tag, " key"}, core_key_o, ek);
      chk({tag, " data"}, core_data_o, ed);
      chk({tag, " op"}, 128'(core_op_o), 128'(eo));
      tick;
      chk({tag, " start_low"}, 128'(core_start_o), 128'(0));
      repeat (lat) tick;
      core_valid_i  = 1'b1;
      core_result_i = res;
      #1;
      chk({tag, " no_rsp_yet"}, 128'(rsp_valid_o), 128'(0));
      tick;
      chk({tag, " rsp_valid"}, 128'(rsp_valid_o), 128'(oh));
      chk({tag, " result"}, rsp_result_o, res);
      chk({tag, " err"}, 128'(rsp_err_o), 128'(0));
      chk({tag, " rsp_owner"}, 128'(owner_o), 128'(who));
      core_valid_i = 1'b0;
      rsp_ready_i  = oh;
      tick;
      rsp_ready_i = '0;
      chk({tag, " idle"}, 128'(busy_o), 128'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      // Reset state
      req_valid_i = '1;
      repeat (3) tick;
      chk("rst busy", 128'(busy_o), 128'(0));
      chk("rst rsp_valid", 128'(rsp_valid_o), 128'(0));
      chk("rst req_ready", 128'(req_ready_o), 128'(0));
      chk("rst start", 128'(core_start_o), 128'(0));
      chk("rst owner", 128'(owner_o), 128'(0));
      req_valid_i = '0;
      rst_i = 1'b0;
      tick;

      // Single job from requester 0, core answers 10 cycles after start
      set_jobs;
      req_valid_i = 2'b01;
      job(0, 9, CT0, 1'b1, "single");

      // Backpressure: requester 1 wins (last=0), holds its result for 20 cycles
      set_jobs;
      req_valid_i = 2'b11;
      #1;
      chk("bp ready", 128'(req_ready_o), 128'(2'b10));
      tick;
      tick;
      core_valid_i  = 1'b1;
      core_result_i = 128'hcafe0001;
      tick;
      core_valid_i = 1'b0;
      rsp_ready_i  = 2'b01;
      for (int i = 0; i < 20; i++) begin
         chk("bp rsp_valid", 128'(rsp_valid_o), 128'(2'b10));
         chk("bp result", rsp_result_o, 128'hcafe0001);
         chk("bp req_ready", 128'(req_ready_o), 128'(0));
         chk("bp busy", 128'(busy_o), 128'(1));
         tick;
      end
      rsp_ready_i = 2'b10;
      tick;
      rsp_ready_i = '0;

      // Timeout: core never completes
      req_valid_i = 2'b01;
      #1;
      chk("to ready", 128'(req_ready_o), 128'(2'b01));
      tick;
      req_valid_i = '0;
      chk("to start", 128'(core_start_o), 128'(1));
      repeat (TO) tick;
      chk("to early", 128'(rsp_valid_o), 128'(0));
      tick;
      chk("to rsp_valid", 128'(rsp_valid_o), 128'(2'b01));
      chk("to err", 128'(rsp_err_o), 128'(1));
      chk("to result", rsp_result_o, 128'(0));
      rsp_ready_i = 2'b01;
      tick;
      rsp_ready_i = '0;

      set_jobs;
      req_valid_i = 2'b10;
      job(1, 3, 128'hbeef0002, 1'b1, "after_to");

      // Stale high valid from the previous job
      set_jobs;
      core_valid_i  = 1'b1;
      core_result_i = 128'h5ca1e;
      req_valid_i   = 2'b01;
      #1;
      chk("stale ready", 128'(req_ready_o), 128'(2'b01));
      tick;
      req_valid_i = '0;
      tick;
      for (int i = 0; i < 5; i++) begin
         chk("stale no_rsp", 128'(rsp_valid_o), 128'(0));
         tick;
      end
      chk("stale busy", 128'(busy_o), 128'(1));
      core_valid_i = 1'b0;
      tick;
      core_valid_i  = 1'b1;
      core_result_i = 128'hf00d0003;
      tick;
      chk("stale rsp_valid", 128'(rsp_valid_o), 128'(2'b01));
      chk("stale result", rsp_result_o, 128'hf00d0003);
      core_valid_i = 1'b0;
      rsp_ready_i  = 2'b01;
      tick;
      rsp_ready_i = '0;

      // Core not ready in IDLE
      core_ready_i = 1'b0;
      req_valid_i  = 2'b11;
      #1;
      chk("nrdy req_ready", 128'(req_ready_o), 128'(0));
      tick;
      chk("nrdy busy", 128'(busy_o), 128'(0));
      req_valid_i  = '0;
      core_ready_i = 1'b1;

      // Reset during RUN
      set_jobs;
      req_valid_i = 2'b01;
      tick;
      req_valid_i = '0;
      tick;
      tick;
      tick;
      chk("mid busy_pre", 128'(busy_o), 128'(1));
      rst_i = 1'b1;
      req_valid_i = 2'b11;
      #1;
      chk("mid busy", 128'(busy_o), 128'(0));
      chk("mid rsp_valid", 128'(rsp_valid_o), 128'(0));
      chk("mid req_ready", 128'(req_ready_o), 128'(0));
      chk("mid key", core_key_o, 128'(0));
      chk("mid data", core_data_o, 128'(0));
      chk("mid op", 128'(core_op_o), 128'(0));
      chk("mid owner", 128'(owner_o), 128'(0));
      chk("mid start", 128'(core_start_o), 128'(0));
      tick;
      rst_i = 1'b0;

      // Contention after reset: grants 0,1,0,1
      job(0, 2, 128'ha0, 1'b0, "cont0");
      job(1, 2, 128'ha1, 1'b0, "cont1");
      job(0, 2, 128'ha2, 1'b0, "cont2");
      job(1, 2, 128'ha3, 1'b0, "cont3");
      req_valid_i = '0;
      tick;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
